fb_scanout_arbiter: RTL and testbench
=====================================

Name: fb_scanout_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two requesters: display scan-out and a pixel writer (the LUT-network result writer).
- Scan-out prefetches the RD_H x RD_V window in raster order into an internal pixel FIFO. The FIFO is drained one pixel per cycle while the timing generator's rd window strobe is high.
- Display reads have priority by FIFO level. The writer is guaranteed bounded service.
- Sits between the timing generator / HDMI encoder and the frame-buffer BRAM.

Parameters:
- RD_H, 480, visible window width in pixels
- RD_V, 272, visible window height in lines
- ADDR_W, 17, frame-buffer address width (must satisfy 2^ADDR_W >= RD_H*RD_V)
- PIX_W, 16, pixel width (RGB565)
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, >= MEM_LAT+4)
- MEM_LAT, 2, RAM read latency in cycles (rdata valid MEM_LAT cycles after a read issue)
- LOW_WM, 6, FIFO level below which display has absolute priority
- WR_MAX_WAIT, 8, maximum cycles a pending write waits while FIFO level >= LOW_WM

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse at start of vertical blanking; restarts scan-out at address 0
- rd  in  1  display window strobe; each high cycle pops one pixel
- pix_out  out  PIX_W  pixel for the current rd cycle (registered, valid the cycle after rd)
- underflow  out  1  sticky flag, set when rd pops an empty FIFO; cleared by frame_start
- wr_req  in  1  writer request; wr_addr/wr_data held stable until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  PIX_W  write data
- wr_ack  out  1  one-cycle pulse: write issued to RAM this cycle
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  PIX_W  RAM write data
- mem_rdata  in  PIX_W  RAM read data

Behaviour:
- Reset values:
  - all outputs 0
  - FIFO empty; credit count 0
  - scan address 0
  - wait counter 0
  - state IDLE
- Credit accounting:
  - credits = FIFO occupancy + reads in flight (shift register of MEM_LAT valid bits).
  - A display read may issue only if credits < FIFO_DEPTH, so the FIFO never overflows.
- Arbitration, evaluated each cycle. Exactly one RAM access per cycle at most.
  1. credits < LOW_WM and scan not done -> display read.
  2. wr_req and (wait_cnt == WR_MAX_WAIT-1 or display cannot/need not read) -> write; wr_ack=1.
  3. credits < FIFO_DEPTH and scan not done -> display read.
  4. otherwise idle: mem_en=0.
- wait_cnt:
  - increments while wr_req is high and not acked;
  - clears on wr_ack or when wr_req is low;
  - saturates at WR_MAX_WAIT-1.
- State machine:
  - IDLE -> SCAN on frame_start.
  - SCAN -> DONE when the read at address RD_H*RD_V-1 issues.
  - DONE -> SCAN on frame_start.
  - Writes are served in all states. Display reads issue only in SCAN.
- Scan address: increments by 1 per display read; no wrap inside a frame.
- frame_start in any state:
  - scan address -> 0; FIFO flushed; credits -> 0; underflow cleared.
  - In-flight read data returning after frame_start is discarded (valid pipe cleared).
  - A write granted in the same cycle still completes.
- FIFO:
  - push when mem_rdata returns valid;
  - pop when rd=1 and not empty;
  - push and pop in the same cycle leave occupancy unchanged.
  - rd on empty: pix_out holds its previous value and underflow is set.
- Latencies:
  - pix_out is updated 1 cycle after the rd cycle.
  - First pixel is available in the FIFO MEM_LAT+1 cycles after the first display read.
- Widths:
  - Credit and occupancy counters are clog2(FIFO_DEPTH)+1 bits.
  - Scan address is ADDR_W bits; compare against RD_H*RD_V-1 at ADDR_W width.

Decomposition:
- Package fb_arb_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - the localparam FRAME_PIX = RD_H*RD_V;
  - the pixel type width.
- One sub-module, pix_sync_fifo: a synchronous FIFO with count output, flush input, and async reset.
- Arbiter, credit logic and read-valid pipe stay in the top module.

Test Plan:
- Reset, then frame_start, with rd low and no writes:
  - 16 reads issue at addresses 0..15;
  - mem_en then drops;
  - FIFO full, credits 16; no further reads.
- Continuous rd after the FIFO fills, with RAM contents = address:
  - pix_out sequence is 0,1,2,... with no gaps;
  - underflow stays 0 across a full 480x272 frame;
  - state reaches DONE after address 130559.
- wr_req held continuously during continuous rd:
  - wr_ack arrives within 8 cycles of each request while level >= 6;
  - RAM written at wr_addr with wr_data;
  - no underflow.
- rd asserted on the first cycle after frame_start (FIFO empty):
  - underflow=1;
  - pix_out unchanged;
  - the next frame_start clears underflow.
- frame_start mid-scan at address 200 with 2 reads in flight:
  - the in-flight data is dropped;
  - the next read issued is address 0;
  - the first popped pixel equals RAM[0].
- Asynchronous rst asserted mid-SCAN between clock edges:
  - all outputs are 0 immediately;
  - after release, no RAM access occurs until frame_start.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared state type and default geometry for the frame-buffer scan-out arbiter.
package fb_arb_pkg;

  localparam int RD_H_DEF  = 480;
  localparam int RD_V_DEF  = 272;
  localparam int FRAME_PIX = RD_H_DEF * RD_V_DEF;
  localparam int PIX_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Counter width able to hold the value DEPTH itself (full FIFO / full credits).
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pix_sync_fifo.sv
// Synchronous pixel FIFO with occupancy count, flush and first-word-fall-through head.
module pix_sync_fifo
  import fb_arb_pkg::*;
#(
  parameter int WIDTH = PIX_W_DEF,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only pointers and count carry state.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Shares one single-port frame-buffer RAM between raster scan-out prefetch and a pixel writer.
module fb_scanout_arbiter
  import fb_arb_pkg::*;
#(
  parameter int RD_H        = RD_H_DEF,
  parameter int RD_V        = RD_V_DEF,
  parameter int ADDR_W      = 17,
  parameter int PIX_W       = PIX_W_DEF,
  parameter int FIFO_DEPTH  = 16,
  parameter int MEM_LAT     = 2,
  parameter int LOW_WM      = 6,
  parameter int WR_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              rd,
  output logic [PIX_W-1:0]  pix_out,
  output logic              underflow,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam int CNT_W  = cnt_bits(FIFO_DEPTH);
  localparam int WAIT_W = $clog2(WR_MAX_WAIT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(RD_H * RD_V - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LOW_WM_C   = CNT_W'(LOW_WM);
  localparam logic [WAIT_W-1:0] WAIT_SAT_C = WAIT_W'(WR_MAX_WAIT - 1);

  scan_state_e       state;
  logic [ADDR_W-1:0] scan_addr;
  logic [MEM_LAT-1:0] vld_pipe;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  credits;
  logic [PIX_W-1:0]  fifo_head;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              rd_on_bus;
  logic              scan_ok;
  logic              rd_can;
  logic              rd_urgent;
  logic              wr_pend;
  logic              grant_rd;
  logic              grant_wr;

  // A read on the bus this cycle is already committed; it enters vld_pipe at the edge.
  assign rd_on_bus = mem_en & ~mem_we;
  // Data landing in the frame_start cycle belongs to the abandoned frame.
  assign fifo_push = vld_pipe[MEM_LAT-1] & ~frame_start;
  assign fifo_pop  = rd & ~fifo_empty;

  pix_sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (fifo_push),
    .din   (mem_rdata),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Every read that has been granted but not yet popped owns one FIFO slot.
  always_comb begin
    credits = fifo_count + CNT_W'(rd_on_bus);
    for (int i = 0; i < MEM_LAT; i++) begin
      credits = credits + CNT_W'(vld_pipe[i]);
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    scan_ok   = (state == SCAN) && !frame_start;
    rd_can    = scan_ok && (credits < DEPTH_C);
    rd_urgent = scan_ok && (credits < LOW_WM_C);
    wr_pend   = wr_req && !wr_ack;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    if (rd_urgent) begin
      grant_rd = 1'b1;
    end else if (wr_pend && ((wait_cnt == WAIT_SAT_C) || !rd_can)) begin
      grant_wr = 1'b1;
    end else if (rd_can) begin
      grant_rd = 1'b1;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scan_addr <= '0;
      vld_pipe  <= '0;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      pix_out   <= '0;
      underflow <= 1'b0;
    end else begin
      mem_en    <= grant_rd | grant_wr;
      mem_we    <= grant_wr;
      wr_ack    <= grant_wr;
      mem_addr  <= grant_wr ? wr_addr : (grant_rd ? scan_addr : '0);
      mem_wdata <= grant_wr ? wr_data : '0;

      if (!wr_pend || grant_wr) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_SAT_C) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (frame_start) vld_pipe <= '0;
      else             vld_pipe <= MEM_LAT'({vld_pipe, rd_on_bus});

      if (frame_start) begin
        state     <= SCAN;
        scan_addr <= '0;
      end else if (grant_rd) begin
        scan_addr <= scan_addr + ADDR_W'(1);
        if (scan_addr == LAST_ADDR) state <= DONE;
      end

      if (fifo_pop) pix_out <= fifo_head;

      if (frame_start)          underflow <= 1'b0;
      else if (rd && fifo_empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Randomized bench for fb_scanout_arbiter against a queue-based transaction model, on a reduced frame.
module tb_fb_scanout_arbiter;

  localparam int RD_H        = 40;
  localparam int RD_V        = 12;
  localparam int ADDR_W      = 9;
  localparam int PIX_W       = 16;
  localparam int FIFO_DEPTH  = 16;
  localparam int MEM_LAT     = 2;
  localparam int LOW_WM      = 6;
  localparam int WR_MAX_WAIT = 8;
  localparam int FRAME       = RD_H * RD_V;
  localparam int RAM_WORDS   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              rd;
  logic [PIX_W-1:0]  pix_out;
  logic              underflow;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_scanout_arbiter #(
    .RD_H (RD_H), .RD_V (RD_V), .ADDR_W (ADDR_W), .PIX_W (PIX_W),
    .FIFO_DEPTH (FIFO_DEPTH), .MEM_LAT (MEM_LAT), .LOW_WM (LOW_WM),
    .WR_MAX_WAIT (WR_MAX_WAIT)
  ) dut (
    .clk (clk), .rst (rst), .frame_start (frame_start), .rd (rd),
    .pix_out (pix_out), .underflow (underflow), .wr_req (wr_req),
    .wr_addr (wr_addr), .wr_data (wr_data), .wr_ack (wr_ack),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
  );

  // Frame-buffer RAM: contents start as their own address, read data MEM_LAT edges after issue.
  logic             init_ram;
  logic [PIX_W-1:0] ram [RAM_WORDS];
  logic [PIX_W-1:0] rd_stage [MEM_LAT];

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= PIX_W'(i);
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    rd_stage[0] <= ram[mem_addr];
    for (int i = 1; i < MEM_LAT; i++) rd_stage[i] <= rd_stage[i-1];
  end
  assign mem_rdata = rd_stage[MEM_LAT-1];

  // Reference model: pixels in the FIFO and reads in flight as queues, expected bus per cycle.
  logic [PIX_W-1:0] ref_mem [RAM_WORDS];
  logic [PIX_W-1:0] fifo_q [$];
  logic [PIX_W-1:0] fl_pix [$];
  int               fl_due [$];
  int               cyc;
  bit               scanning;
  int               m_addr;
  int               m_wait;
  bit               m_uf;
  logic [PIX_W-1:0] m_pix;
  bit               m_popped;
  bit               e_en, e_we, e_ack;
  int               e_addr;
  logic [PIX_W-1:0] e_wdata;
  int               pend_cycles;
  bit               saw_urgent;
  bit               obs_rd;
  int               obs_rd_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete(); fl_pix.delete(); fl_due.delete();
    cyc = 0; scanning = 0; m_addr = 0; m_wait = 0; m_uf = 0; m_pix = '0;
    m_popped = 0; e_en = 0; e_we = 0; e_ack = 0; e_addr = 0; e_wdata = '0;
    pend_cycles = 0; saw_urgent = 0;
  endtask

  task automatic model_step();
    int  credits;
    bit  scan_ok, can, urgent, pend, do_rd, do_wr, was_empty;
    credits = fifo_q.size() + fl_pix.size();
    scan_ok = scanning && !frame_start;
    can     = scan_ok && (credits < FIFO_DEPTH);
    urgent  = scan_ok && (credits < LOW_WM);
    pend    = wr_req && !e_ack;
    do_rd = 0; do_wr = 0;
    if (urgent)                                          do_rd = 1;
    else if (pend && (m_wait >= WR_MAX_WAIT-1 || !can))  do_wr = 1;
    else if (can)                                        do_rd = 1;

    if (pend) begin
      pend_cycles++;
      if (urgent) saw_urgent = 1;
    end else begin
      pend_cycles = 0; saw_urgent = 0;
    end
    if (do_wr) begin
      if (!saw_urgent) check("wr_wait_bound", 32'(pend_cycles <= WR_MAX_WAIT), 1);
      pend_cycles = 0; saw_urgent = 0;
    end
    if (!pend || do_wr)            m_wait = 0;
    else if (m_wait < WR_MAX_WAIT-1) m_wait++;

    was_empty = (fifo_q.size() == 0);
    m_popped = 0;
    if (rd && !was_empty) begin
      m_pix = fifo_q.pop_front();
      m_popped = 1;
    end
    if (frame_start)            m_uf = 0;
    else if (rd && was_empty)   m_uf = 1;

    if (frame_start) begin
      fifo_q.delete(); fl_pix.delete(); fl_due.delete();
    end else begin
      while (fl_due.size() > 0 && fl_due[0] <= cyc) begin
        fifo_q.push_back(fl_pix.pop_front());
        void'(fl_due.pop_front());
      end
    end

    e_en = do_rd | do_wr; e_we = do_wr; e_ack = do_wr;
    if (do_wr) begin
      e_addr = int'(wr_addr); e_wdata = wr_data;
      ref_mem[wr_addr] = wr_data;
    end
    if (do_rd) begin
      e_addr = m_addr;
      fl_pix.push_back(ref_mem[m_addr]);
      fl_due.push_back(cyc + MEM_LAT + 1);
      if (m_addr == FRAME-1) scanning = 0;
      m_addr++;
    end
    if (frame_start) begin
      scanning = 1; m_addr = 0;
    end
    cyc++;
  endtask

  task automatic compare_outputs();
    check("mem_en", 32'(mem_en), 32'(e_en));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("wr_ack", 32'(wr_ack), 32'(e_ack));
    if (e_en) check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check("pix_out", 32'(pix_out), 32'(m_pix));
    check("underflow", 32'(underflow), 32'(m_uf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    obs_rd      = mem_en && !mem_we;
    obs_rd_addr = int'(mem_addr);
  endtask

  task automatic new_write();
    wr_addr = ADDR_W'($urandom_range(0, FRAME-1));
    wr_data = PIX_W'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int               n, tot, last, seq, acks;
    bit               chk_pend, found;
    logic [ADDR_W-1:0] pa;
    logic [PIX_W-1:0]  pd, prev_pix;

    rst = 1; frame_start = 0; rd = 0; wr_req = 0; wr_addr = '0; wr_data = '0;
    init_ram = 1;
    for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = PIX_W'(i);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_wr_ack", 32'(wr_ack), 0);
    check("rst_pix_out", 32'(pix_out), 0);
    check("rst_underflow", 32'(underflow), 0);
    init_ram = 0; rst = 0;
    repeat (4) tick();

    // Prefetch after frame_start: exactly FIFO_DEPTH reads at 0..15, then the bus goes quiet.
    frame_start = 1; tick(); frame_start = 0;
    n = 0;
    repeat (30) begin
      tick();
      if (obs_rd) begin
        check("fill_addr", 32'(obs_rd_addr), 32'(n));
        n++;
      end
    end
    check("fill_reads", 32'(n), 32'(FIFO_DEPTH));

    // Continuous rd through a whole frame: gapless raster sequence, no underflow, then DONE.
    rd = 1; seq = 0; tot = n; last = n - 1;
    for (int c = 0; c < FRAME + 200 && seq < FRAME; c++) begin
      tick();
      if (obs_rd) begin tot++; last = obs_rd_addr; end
      if (m_popped) begin
        check("pix_seq", 32'(pix_out), 32'(seq));
        seq++;
      end
      if (seq == FRAME) rd = 0;
    end
    rd = 0;
    check("seq_len", 32'(seq), 32'(FRAME));
    check("frame_uf", 32'(underflow), 0);
    check("frame_reads", 32'(tot), 32'(FRAME));
    check("last_addr", 32'(last), 32'(FRAME-1));
    n = 0;
    repeat (10) begin tick(); if (mem_en) n++; end
    check("done_idle", 32'(n), 0);

    // Writer held continuously during continuous rd.
    frame_start = 1; tick(); frame_start = 0;
    repeat (25) tick();
    rd = 1; wr_req = 1; new_write(); acks = 0; chk_pend = 0;
    repeat (60) begin
      tick();
      if (chk_pend) begin check("ram_wr", 32'(ram[pa]), 32'(pd)); chk_pend = 0; end
      if (wr_ack) begin pa = wr_addr; pd = wr_data; chk_pend = 1; acks++; new_write(); end
    end
    wr_req = 0; rd = 0;
    tick();
    if (chk_pend) check("ram_wr", 32'(ram[pa]), 32'(pd));
    check("wr_uf", 32'(underflow), 0);
    check("wr_acks", 32'(acks >= 5), 1);

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      frame_start = ($urandom_range(0, 299) == 0);
      rd = frame_start ? 1'b0 : 1'($urandom_range(0, 1));
      if (!wr_req) begin
        if ($urandom_range(0, 3) == 0) begin wr_req = 1; new_write(); end
      end
      tick();
      if (wr_ack) begin
        wr_req = 1'($urandom_range(0, 1));
        new_write();
      end
    end
    frame_start = 0; rd = 0; wr_req = 0;
    tick();

    // rd on the very first cycle after frame_start pops an empty FIFO.
    frame_start = 1; tick(); frame_start = 0;
    prev_pix = m_pix;
    rd = 1; tick(); rd = 0;
    check("uf_set", 32'(underflow), 1);
    check("uf_pix_hold", 32'(pix_out), 32'(prev_pix));
    repeat (5) tick();
    check("uf_sticky", 32'(underflow), 1);
    frame_start = 1; tick(); frame_start = 0;
    check("uf_clr", 32'(underflow), 0);

    // Restart mid-scan at address 200 with reads still in flight.
    rd = 1; found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      tick();
      if (obs_rd && obs_rd_addr == 200) found = 1;
    end
    check("reach_200", 32'(found), 1);
    rd = 0; frame_start = 1; tick(); frame_start = 0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (obs_rd) begin
        found = 1;
        check("restart_addr", 32'(obs_rd_addr), 0);
      end
    end
    check("restart_seen", 32'(found), 1);
    repeat (6) tick();
    rd = 1; tick(); rd = 0;
    check("restart_pix", 32'(pix_out), 32'(ref_mem[0]));

    // Asynchronous reset between edges while scanning with a write pending.
    frame_start = 1; tick(); frame_start = 0;
    wr_req = 1; new_write();
    repeat (8) tick();
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("arst_mem_en", 32'(mem_en), 0);
    check("arst_mem_we", 32'(mem_we), 0);
    check("arst_mem_addr", 32'(mem_addr), 0);
    check("arst_mem_wdata", 32'(mem_wdata), 0);
    check("arst_wr_ack", 32'(wr_ack), 0);
    check("arst_pix_out", 32'(pix_out), 0);
    check("arst_underflow", 32'(underflow), 0);
    model_reset();
    wr_req = 0;
    @(negedge clk);
    rst = 0;
    n = 0;
    repeat (20) begin tick(); if (mem_en) n++; end
    check("post_rst_idle", 32'(n), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
